// File: rtl/wr_rr_arbiter_pkg.sv
// rtl/wr_rr_arbiter_pkg.sv - shared types and helpers for the write-path round-robin arbiter
package wr_rr_arbiter_pkg;

    localparam int SEL_W     = 4;
    localparam int MAX_PORTS = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
        return (idx == SEL_W'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/wr_rr_arbiter_if.sv
// rtl/wr_rr_arbiter_if.sv - request/grant bundle between ingress ports, arbiter and selector
interface wr_rr_arbiter_if
    import wr_rr_arbiter_pkg::*;
#(
    parameter int num_of_ports = 16
) ();

    logic [num_of_ports-1:0] req;
    logic [num_of_ports-1:0] eop;
    logic                    enable;
    logic [SEL_W-1:0]        select;
    logic [SEL_W-1:0]        pre_selected;
    logic                    busy;
    logic [num_of_ports-1:0] grant;
    logic                    timeout_err;

    modport master (
        input  req, eop,
        output enable, select, pre_selected, busy, grant, timeout_err
    );

    modport slave (
        output req, eop,
        input  enable, select, pre_selected, busy, grant, timeout_err
    );

endinterface

// File: rtl/wr_rr_arbiter_rr_pick.sv
// rtl/wr_rr_arbiter_rr_pick.sv - first set bit of vec at or after ptr, scanning circularly
module rr_pick
    import wr_rr_arbiter_pkg::*;
#(
    parameter int num_of_ports = 16
) (
    input  logic [num_of_ports-1:0] vec,
    input  logic [SEL_W-1:0]        ptr,
    output logic [SEL_W-1:0]        idx,
    output logic                    found
);

    logic [MAX_PORTS-1:0] vec_ext;
    assign vec_ext = MAX_PORTS'(vec);

    // Scan offsets from farthest to nearest so the nearest hit overwrites earlier ones.
    always_comb begin
        int j;
        logic [SEL_W-1:0] jj;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = num_of_ports - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= num_of_ports) j = j - num_of_ports;
            jj = SEL_W'(j);
            if (vec_ext[jj]) begin
                idx   = jj;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_rr_arbiter.sv
// rtl/wr_rr_arbiter.sv - packet-level round-robin arbiter driving the write channel selector
module wr_rr_arbiter
    import wr_rr_arbiter_pkg::*;
#(
    parameter int num_of_ports = 16,
    parameter int max_beats    = 64,
    parameter int cnt_width    = 7
) (
    input  logic              clk,
    input  logic              rst,
    wr_rr_arbiter_if.master   bus
);

    arb_state_t              state;
    logic [SEL_W-1:0]        ptr;
    logic [cnt_width-1:0]    beat_cnt;
    logic                    pend;

    logic [SEL_W-1:0]        pick_idx;
    logic                    pick_found;
    logic [SEL_W-1:0]        la_idx;
    logic                    la_found;
    logic [SEL_W-1:0]        next_sel;
    logic [SEL_W-1:0]        mask_sel;
    logic [SEL_W-1:0]        la_ptr;
    logic [num_of_ports-1:0] la_vec;
    logic [MAX_PORTS-1:0]    eop_ext;
    logic                    eop_hit;
    logic                    limit_hit;

    function automatic logic [num_of_ports-1:0] onehot(input logic [SEL_W-1:0] i);
        return {{(num_of_ports-1){1'b0}}, 1'b1} << i;
    endfunction

    // The lookahead masks the port about to be (or currently) granted, so busy is
    // already valid on the first beat of every packet.
    assign next_sel  = (state == IDLE) ? pick_idx : bus.pre_selected;
    assign mask_sel  = (state == XFER) ? bus.select : next_sel;
    assign la_vec    = bus.req & ~onehot(mask_sel);
    assign la_ptr    = wrap_inc(mask_sel, num_of_ports);
    assign eop_ext   = MAX_PORTS'(bus.eop);
    assign eop_hit   = eop_ext[bus.select];
    assign limit_hit = (beat_cnt == cnt_width'(max_beats - 1));

    rr_pick #(.num_of_ports(num_of_ports)) u_pick (
        .vec   (bus.req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    rr_pick #(.num_of_ports(num_of_ports)) u_lookahead (
        .vec   (la_vec),
        .ptr   (la_ptr),
        .idx   (la_idx),
        .found (la_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            ptr              <= '0;
            beat_cnt         <= '0;
            pend             <= 1'b0;
            bus.enable       <= 1'b0;
            bus.select       <= '0;
            bus.pre_selected <= '0;
            bus.busy         <= 1'b0;
            bus.grant        <= '0;
            bus.timeout_err  <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        bus.select <= pick_idx;
                        bus.enable <= 1'b1;
                        bus.grant  <= onehot(pick_idx);
                        bus.busy   <= la_found;
                        if (la_found) bus.pre_selected <= la_idx;
                        beat_cnt   <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (la_found) bus.pre_selected <= la_idx;
                    if (eop_hit || limit_hit) begin
                        bus.enable      <= 1'b0;
                        bus.grant       <= '0;
                        bus.busy        <= 1'b0;
                        pend            <= la_found;
                        ptr             <= wrap_inc(bus.select, num_of_ports);
                        bus.timeout_err <= !eop_hit;
                        state           <= GAP;
                    end else begin
                        bus.busy <= la_found;
                    end
                end
                GAP: begin
                    if (pend) begin
                        bus.select <= bus.pre_selected;
                        bus.enable <= 1'b1;
                        bus.grant  <= onehot(bus.pre_selected);
                        bus.busy   <= la_found;
                        if (la_found) bus.pre_selected <= la_idx;
                        beat_cnt   <= '0;
                        pend       <= 1'b0;
                        state      <= XFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_rr_arbiter.sv
// tb/tb_wr_rr_arbiter.sv - directed self-checking bench for wr_rr_arbiter
module tb_wr_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wr_rr_arbiter_if #(.num_of_ports(16)) bus ();

    wr_rr_arbiter #(
        .num_of_ports (16),
        .max_beats    (8),
        .cnt_width    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [3:0] sel,
                           input logic [15:0] gnt, input logic bsy);
        chk({tag, "_enable"}, 32'(bus.enable), 32'(en));
        chk({tag, "_select"}, 32'(bus.select), 32'(sel));
        chk({tag, "_grant"},  32'(bus.grant),  32'(gnt));
        chk({tag, "_busy"},   32'(bus.busy),   32'(bsy));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        bus.req = '0;
        bus.eop = '0;
        #3;
        chk_out("reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk("reset_pre", 32'(bus.pre_selected), 32'd0);
        chk("reset_tmo", 32'(bus.timeout_err), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Fairness between ports 0 and 15 with 1-beat packets
        bus.req = 16'h8001;
        tick();
        chk_out("fair1", 1'b1, 4'd0, 16'h0001, 1'b1);
        chk("fair1_pre", 32'(bus.pre_selected), 32'd15);
        bus.eop = 16'h0001;
        tick();
        chk_out("fair1_gap", 1'b0, 4'd0, 16'h0000, 1'b0);
        bus.eop = '0;
        tick();
        chk_out("fair2", 1'b1, 4'd15, 16'h8000, 1'b1);
        chk("fair2_pre", 32'(bus.pre_selected), 32'd0);
        bus.eop = 16'h8000;
        tick();
        chk("fair2_gap", 32'(bus.enable), 32'd0);
        bus.eop = '0;
        tick();
        chk_out("fair3", 1'b1, 4'd0, 16'h0001, 1'b1);
        chk("fair3_pre", 32'(bus.pre_selected), 32'd15);
        bus.eop = 16'h0001;
        tick();
        chk("fair3_gap", 32'(bus.enable), 32'd0);
        bus.eop = '0;
        tick();
        chk_out("fair4", 1'b1, 4'd15, 16'h8000, 1'b1);
        bus.eop = 16'h8000;
        bus.req = '0;
        tick();
        chk("fair4_end", 32'(bus.enable), 32'd0);
        bus.eop = '0;
        tick();
        chk("fair_idle", 32'(bus.enable), 32'd0);

        // Single request on port 2, eop on third beat
        bus.req = 16'h0004;
        tick();
        chk_out("single", 1'b1, 4'd2, 16'h0004, 1'b0);
        tick();
        tick();
        chk("single_beat3", 32'(bus.enable), 32'd1);
        bus.eop = 16'h0004;
        tick();
        chk_out("single_end", 1'b0, 4'd2, 16'h0000, 1'b0);
        bus.eop = '0;
        bus.req = '0;
        tick();

        // ptr is now 3: ports 0 and 3 requesting picks 3; eop from port 0 ignored
        bus.req = 16'h0009;
        tick();
        chk_out("ptr3", 1'b1, 4'd3, 16'h0008, 1'b1);
        chk("ptr3_pre", 32'(bus.pre_selected), 32'd0);
        bus.eop = 16'h0001;
        tick();
        chk_out("foreign_eop", 1'b1, 4'd3, 16'h0008, 1'b1);
        bus.eop = 16'h0008;
        bus.req = '0;
        tick();
        chk("own_eop", 32'(bus.enable), 32'd0);
        bus.eop = '0;
        tick();

        // Wrap-around: port 14 leaves ptr=15, then req=0x8002
        bus.req = 16'h4000;
        tick();
        chk("wrap_p14", 32'(bus.select), 32'd14);
        bus.eop = 16'h4000;
        bus.req = '0;
        tick();
        bus.eop = '0;
        tick();
        bus.req = 16'h8002;
        tick();
        chk_out("wrap15", 1'b1, 4'd15, 16'h8000, 1'b1);
        chk("wrap15_pre", 32'(bus.pre_selected), 32'd1);
        bus.eop = 16'h8000;
        tick();
        chk("wrap_gap", 32'(bus.enable), 32'd0);
        bus.eop = '0;
        tick();
        chk_out("wrap1", 1'b1, 4'd1, 16'h0002, 1'b1);
        bus.eop = 16'h0002;
        bus.req = '0;
        tick();
        bus.eop = '0;
        tick();

        // Watchdog: ptr=2, port 4 streams 8 beats with no eop
        bus.req = 16'h0010;
        tick();
        chk_out("wd_start", 1'b1, 4'd4, 16'h0010, 1'b0);
        bus.req = '0;
        for (int b = 2; b <= 8; b++) begin
            tick();
            chk($sformatf("wd_beat%0d_en", b), 32'(bus.enable), 32'd1);
            chk($sformatf("wd_beat%0d_tmo", b), 32'(bus.timeout_err), 32'd0);
        end
        tick();
        chk("wd_drop", 32'(bus.enable), 32'd0);
        chk("wd_pulse", 32'(bus.timeout_err), 32'd1);
        tick();
        chk("wd_pulse_end", 32'(bus.timeout_err), 32'd0);

        // Watchdog boundary: eop on beat 8 is a normal exit
        bus.req = 16'h0010;
        tick();
        chk_out("wd2_start", 1'b1, 4'd4, 16'h0010, 1'b0);
        bus.req = '0;
        for (int b = 2; b <= 7; b++) tick();
        tick();
        chk("wd2_beat8", 32'(bus.enable), 32'd1);
        bus.eop = 16'h0010;
        tick();
        chk("wd2_drop", 32'(bus.enable), 32'd0);
        chk("wd2_no_tmo", 32'(bus.timeout_err), 32'd0);
        bus.eop = '0;
        tick();
        chk("wd2_no_tmo2", 32'(bus.timeout_err), 32'd0);

        // Reset mid-packet on port 5 (ptr=5)
        bus.req = 16'h0020;
        tick();
        chk("rst_p5", 32'(bus.select), 32'd5);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 4'd0, 16'h0000, 1'b0);
        bus.req = '0;
        tick();
        rst = 1'b1;
        bus.req = 16'h0020;
        tick();
        chk_out("rst_after", 1'b1, 4'd5, 16'h0020, 1'b0);
        bus.eop = 16'h0020;
        bus.req = '0;
        tick();
        bus.eop = '0;
        tick();

        // ptr is 6 here; after reset, ports 0 and 6 requesting must pick 0
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        bus.req = 16'h0041;
        tick();
        chk_out("rst_ptr", 1'b1, 4'd0, 16'h0001, 1'b1);
        chk("rst_ptr_pre", 32'(bus.pre_selected), 32'd6);
        bus.eop = 16'h0001;
        bus.req = '0;
        tick();
        bus.eop = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
